response_collector: RTL and testbench
=====================================

RESPONSE_COLLECTOR -- requirements
Module: response_collector

Interface
REQ-001 SHALL have parameter NUM_LOOPS, default 4, meaning number of TERO loops; even, >=2.
REQ-002 SHALL have parameter COUNT_BITS, default 32, meaning width of the shared oscillation counter.
REQ-003 SHALL have parameter REPETITIONS_BITS, default 13, meaning averaging shift is REPETITIONS_BITS-1.
REQ-004 SHALL have parameter FREQ_BITS, default 16, meaning stored per-loop average width.
REQ-005 SHALL have one clock and an asynchronous, active-low reset: clk input 1 (system clock); reset input 1 (asynchronous active-low reset).
REQ-006 SHALL have port store_response_puf input 1: one-cycle capture strobe from the evaluation FSM.
REQ-007 SHALL have port select_puf input $clog2(NUM_LOOPS-1)+1: loop index, valid with the strobe.
REQ-008 SHALL have port count_in input COUNT_BITS: shared counter value, valid with the strobe.
REQ-009 SHALL have port eval_done input 1: evaluation-complete level from the FSM.
REQ-010 SHALL have port resp_data output NUM_LOOPS/2: response word.
REQ-011 SHALL have port resp_valid output 1 and port resp_ready input 1: response handshake.
REQ-012 SHALL have port missing_err output 1 (sticky, some loop not captured) and port dup_err output 1 (sticky, loop captured twice).

Function
REQ-013 SHALL use states IDLE, COLLECT, COMPARE, OUTPUT.
REQ-014 IDLE: clear all slot-valid bits; on store_response_puf go to COLLECT and capture the strobe in the same cycle.
REQ-015 Capture: freq[select_puf] <= count_in >> (REPETITIONS_BITS-1), saturated to 2^FREQ_BITS-1 if wider; slot-valid set; one-cycle latency.
REQ-016 Capture with select_puf >= NUM_LOOPS SHALL be ignored and set dup_err.
REQ-017 Capture into an already-valid slot SHALL overwrite and set dup_err.
REQ-018 COLLECT: on rising edge of eval_done go to COMPARE; if any slot-valid is clear, set missing_err; missing slots read as 0.
REQ-019 Strobe in the same cycle as the eval_done rise SHALL be captured before COMPARE starts.
REQ-020 COMPARE: one pair per cycle, k = 0..NUM_LOOPS/2-1; resp bit k = 1 iff freq[2k] > freq[2k+1]; equal gives 0; NUM_LOOPS/2 cycles total.
REQ-021 OUTPUT: resp_valid=1, resp_data stable while resp_valid=1 and resp_ready=0.
REQ-022 Transfer on resp_valid && resp_ready; next cycle resp_valid=0, state IDLE.
REQ-023 Strobes in COMPARE or OUTPUT SHALL be ignored and set dup_err.
REQ-024 missing_err/dup_err clear only on reset or on the IDLE->COLLECT transition.

Reset
REQ-025 reset low SHALL immediately force state IDLE, resp_valid=0, resp_data=0, missing_err=0, dup_err=0, all slot-valid and freq entries 0.
REQ-026 Reset asserted mid-COLLECT/COMPARE/OUTPUT SHALL discard the in-progress response; no resp_valid after release until a new full sequence.
REQ-027 Release is synchronised internally; first capture accepted on the second clk edge after reset rises.

Configuration
REQ-028 Macro RESPONSE_COLLECTOR_RAW_READOUT_EN defined: adds ports raw_addr input ($clog2(NUM_LOOPS-1)+1) and raw_data output FREQ_BITS, raw_data = freq[raw_addr] registered, one-cycle latency, out-of-range address returns 0.
REQ-029 Macro undefined: those ports absent; no other behaviour change.

Verification
REQ-030 NUM_LOOPS=4, shift 12; strobes loops 0..3 with count_in 0x5000,0x4000,0x3000,0x3800; eval_done rise -> resp_data=2'b01 after 2 COMPARE cycles, both errors 0.
REQ-031 Same sequence with resp_ready held low 10 cycles -> resp_valid and resp_data stable 10 cycles, single transfer, then IDLE.
REQ-032 Only loops 0,1,2 captured (loop 2 count 0x1000) then eval_done -> missing_err=1, bit1=1 (loop 3 read as 0).
REQ-033 Loop 1 strobed twice (0x2000 then 0x6000), loop 0 0x5000 -> dup_err=1, bit0=0 (overwrite used).
REQ-034 count_in=0xFFFFFFFF with FREQ_BITS=16 -> freq saturates to 0xFFFF; equal-pair compare yields 0.
REQ-035 reset low during OUTPUT with resp_ready=0 -> resp_valid drops immediately, errors 0, no response after release.

Source files
------------

// File: rtl/response_collector_if.sv
// response_collector_if
//   Bundles the capture-side and response-side signals of the response
//   collector so the evaluation FSM (or a bench) and the collector share one
//   port.
//
//   Capture side (master drives):
//     store_response_puf  one-cycle capture strobe
//     select_puf          loop index, valid with the strobe
//     count_in            shared oscillation counter value, valid with the strobe
//     eval_done           evaluation-complete level
//   Response side:
//     resp_data           response word (slave drives)
//     resp_valid          response available (slave drives)
//     resp_ready          consumer can accept (master drives)
//     missing_err         sticky: some loop was not captured (slave drives)
//     dup_err             sticky: a loop was captured twice or a strobe was
//                         out of place (slave drives)
//
//   Handshake: a response transfers on any rising clk edge where resp_valid
//   and resp_ready are both 1. While resp_valid is 1 and resp_ready is 0,
//   resp_valid stays 1 and resp_data holds its value. resp_valid may not wait
//   on resp_ready, and resp_ready may be driven independently of resp_valid.
interface response_collector_if #(
    parameter int NUM_LOOPS  = 4,
    parameter int COUNT_BITS = 32
) ();
    localparam int SEL_W = $clog2(NUM_LOOPS - 1) + 1;

    logic                   store_response_puf;
    logic [SEL_W-1:0]       select_puf;
    logic [COUNT_BITS-1:0]  count_in;
    logic                   eval_done;
    logic [NUM_LOOPS/2-1:0] resp_data;
    logic                   resp_valid;
    logic                   resp_ready;
    logic                   missing_err;
    logic                   dup_err;

    modport master (
        output store_response_puf, select_puf, count_in, eval_done, resp_ready,
        input  resp_data, resp_valid, missing_err, dup_err
    );

    modport slave (
        input  store_response_puf, select_puf, count_in, eval_done, resp_ready,
        output resp_data, resp_valid, missing_err, dup_err
    );
endinterface

// File: rtl/response_collector.sv
// response_collector
//   Collects one averaged oscillation count per TERO loop, compares loops
//   pairwise (loop 2k against loop 2k+1) and hands out the resulting response
//   word over a valid/ready handshake.
//
//   Ports:
//     clk        system clock
//     reset      asynchronous active-low reset; release is synchronised
//                internally, so the first capture is taken on the second clk
//                edge after reset rises
//     bus        response_collector_if.slave (capture strobe, loop index,
//                counter value, eval_done, response handshake, sticky errors)
//     state_dbg  current FSM state (0 IDLE, 1 COLLECT, 2 COMPARE, 3 OUTPUT)
//
//   Optional feature, macro RESPONSE_COLLECTOR_RAW_READOUT_EN:
//     raw_addr   loop index to read back
//     raw_data   stored average of that loop, registered (one-cycle latency),
//                0 for an out-of-range address
module response_collector #(
    parameter int NUM_LOOPS        = 4,
    parameter int COUNT_BITS       = 32,
    parameter int REPETITIONS_BITS = 13,
    parameter int FREQ_BITS        = 16
) (
    input  logic                                 clk,
    input  logic                                 reset,
    response_collector_if.slave                  bus,
`ifdef RESPONSE_COLLECTOR_RAW_READOUT_EN
    input  logic [$clog2(NUM_LOOPS-1):0]         raw_addr,
    output logic [FREQ_BITS-1:0]                 raw_data,
`endif
    output logic [1:0]                           state_dbg
);
    localparam int SEL_W  = $clog2(NUM_LOOPS - 1) + 1;
    localparam int PAIRS  = NUM_LOOPS / 2;
    localparam int CMP_W  = (PAIRS > 1) ? $clog2(PAIRS) : 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        COMPARE = 2'd2,
        OUTPUT  = 2'd3
    } state_t;

    state_t                 state;
    logic                   run;
    logic                   eval_q;
    logic [FREQ_BITS-1:0]   freq [NUM_LOOPS];
    logic [NUM_LOOPS-1:0]   slot_valid;
    logic [CMP_W-1:0]       cmp_idx;

    logic [COUNT_BITS-1:0]  shifted;
    logic [FREQ_BITS-1:0]   sat_val;
    logic [NUM_LOOPS-1:0]   sel_hot;
    logic [NUM_LOOPS-1:0]   cap_mask;
    logic                   sel_ok;
    logic                   eval_rise;
    logic [FREQ_BITS-1:0]   cmp_a;
    logic [FREQ_BITS-1:0]   cmp_b;

    assign state_dbg = state;
    assign eval_rise = bus.eval_done && !eval_q;
    assign shifted   = bus.count_in >> (REPETITIONS_BITS - 1);

    // Clamp the averaged count to the stored width.
    always_comb begin
        sat_val = shifted[FREQ_BITS-1:0];
        if ((shifted >> FREQ_BITS) != '0) begin
            sat_val = '1;
        end
    end

    // One-hot decode of the loop index; an out-of-range index decodes to zero.
    always_comb begin
        sel_hot = '0;
        for (int i = 0; i < NUM_LOOPS; i++) begin
            sel_hot[i] = (bus.select_puf == SEL_W'(i));
        end
    end

    assign sel_ok   = |sel_hot;
    assign cap_mask = bus.store_response_puf ? sel_hot : '0;

    // Operands of the pair under comparison; slots never captured read as 0.
    always_comb begin
        cmp_a = '0;
        cmp_b = '0;
        for (int k = 0; k < PAIRS; k++) begin
            if (cmp_idx == CMP_W'(k)) begin
                cmp_a = slot_valid[2*k]   ? freq[2*k]   : '0;
                cmp_b = slot_valid[2*k+1] ? freq[2*k+1] : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run         <= 1'b0;
            eval_q      <= 1'b0;
            state       <= IDLE;
            slot_valid  <= '0;
            cmp_idx     <= '0;
            bus.resp_valid  <= 1'b0;
            bus.resp_data   <= '0;
            bus.missing_err <= 1'b0;
            bus.dup_err     <= 1'b0;
            for (int i = 0; i < NUM_LOOPS; i++) begin
                freq[i] <= '0;
            end
        end else begin
            // Single-stage release: logic below acts from the second edge on.
            run    <= 1'b1;
            eval_q <= bus.eval_done;
            if (run) begin
                case (state)
                    IDLE: begin
                        slot_valid <= '0;
                        if (bus.store_response_puf) begin
                            state           <= COLLECT;
                            bus.missing_err <= 1'b0;
                            bus.dup_err     <= !sel_ok;
                            slot_valid      <= cap_mask;
                            for (int i = 0; i < NUM_LOOPS; i++) begin
                                if (cap_mask[i]) freq[i] <= sat_val;
                            end
                        end
                    end
                    COLLECT: begin
                        if (bus.store_response_puf) begin
                            if (!sel_ok || ((slot_valid & sel_hot) != '0)) begin
                                bus.dup_err <= 1'b1;
                            end
                            slot_valid <= slot_valid | cap_mask;
                            for (int i = 0; i < NUM_LOOPS; i++) begin
                                if (cap_mask[i]) freq[i] <= sat_val;
                            end
                        end
                        // A strobe in the same cycle counts toward completeness.
                        if (eval_rise) begin
                            state         <= COMPARE;
                            cmp_idx       <= '0;
                            bus.resp_data <= '0;
                            if (!(&(slot_valid | cap_mask))) begin
                                bus.missing_err <= 1'b1;
                            end
                        end
                    end
                    COMPARE: begin
                        if (bus.store_response_puf) bus.dup_err <= 1'b1;
                        for (int k = 0; k < PAIRS; k++) begin
                            if (cmp_idx == CMP_W'(k)) bus.resp_data[k] <= (cmp_a > cmp_b);
                        end
                        if (cmp_idx == CMP_W'(PAIRS - 1)) begin
                            state          <= OUTPUT;
                            bus.resp_valid <= 1'b1;
                        end else begin
                            cmp_idx <= cmp_idx + 1'b1;
                        end
                    end
                    OUTPUT: begin
                        if (bus.store_response_puf) bus.dup_err <= 1'b1;
                        if (bus.resp_ready) begin
                            bus.resp_valid <= 1'b0;
                            state          <= IDLE;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

`ifdef RESPONSE_COLLECTOR_RAW_READOUT_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            raw_data <= '0;
        end else begin
            raw_data <= '0;
            for (int i = 0; i < NUM_LOOPS; i++) begin
                if (raw_addr == SEL_W'(i)) raw_data <= freq[i];
            end
        end
    end
`endif
endmodule

// File: tb/tb_response_collector.sv
module tb_response_collector;
    localparam int NUM_LOOPS  = 4;
    localparam int COUNT_BITS = 32;
    localparam int FREQ_BITS  = 16;
    localparam int SEL_W      = $clog2(NUM_LOOPS - 1) + 1;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [1:0] state_dbg;
`ifdef RESPONSE_COLLECTOR_RAW_READOUT_EN
    logic [SEL_W-1:0]     raw_addr = '0;
    logic [FREQ_BITS-1:0] raw_data;
`endif

    response_collector_if #(.NUM_LOOPS(NUM_LOOPS), .COUNT_BITS(COUNT_BITS)) bus ();

    response_collector #(
        .NUM_LOOPS(NUM_LOOPS), .COUNT_BITS(COUNT_BITS),
        .REPETITIONS_BITS(13), .FREQ_BITS(FREQ_BITS)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .bus       (bus.slave),
`ifdef RESPONSE_COLLECTOR_RAW_READOUT_EN
        .raw_addr  (raw_addr),
        .raw_data  (raw_data),
`endif
        .state_dbg (state_dbg)
    );

    // clock/reset block
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    int vectors = 0;
    int miscompares = 0;
    // scoreboard entry: {resp_data[1:0], missing_err, dup_err}
    logic [3:0] exp_q[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // driver tasks
    task automatic strobe(input int sel, input logic [31:0] cnt);
        bus.store_response_puf = 1'b1;
        bus.select_puf = SEL_W'(sel);
        bus.count_in = cnt;
        @(posedge clk); #1;
        bus.store_response_puf = 1'b0;
    endtask

    task automatic eval_pulse(input bit with_strobe, input int sel, input logic [31:0] cnt);
        bus.eval_done = 1'b1;
        bus.store_response_puf = with_strobe;
        bus.select_puf = SEL_W'(sel);
        bus.count_in = cnt;
        @(posedge clk); #1;
        bus.eval_done = 1'b0;
        bus.store_response_puf = 1'b0;
    endtask

    task automatic expect_resp(input logic [1:0] data, input logic miss, input logic dup);
        exp_q.push_back({data, miss, dup});
    endtask

    task automatic wait_resp(input int hold, input bit chk_lat);
        int cyc = 0;
        logic [3:0] e;
        bus.resp_ready = (hold == 0);
        do begin
            @(negedge clk);
            cyc++;
        end while (!bus.resp_valid && cyc < 40);
        check("resp_valid_seen", 32'(bus.resp_valid), 32'd1);
        if (!bus.resp_valid) return;
        if (chk_lat) check("latency", 32'(cyc), 32'd3);
        assert (exp_q.size() != 0) else begin
            miscompares++;
            $error("FAIL exp_q_empty: observed unexpected response %0h expected none", bus.resp_data);
        end
        if (exp_q.size() == 0) return;
        e = exp_q.pop_front();
        check("resp_data", 32'(bus.resp_data), 32'(e[3:2]));
        check("missing_err", 32'(bus.missing_err), 32'(e[1]));
        check("dup_err", 32'(bus.dup_err), 32'(e[0]));
        for (int i = 1; i < hold; i++) begin
            @(negedge clk);
            check("hold_valid", 32'(bus.resp_valid), 32'd1);
            check("hold_data", 32'(bus.resp_data), 32'(e[3:2]));
        end
        bus.resp_ready = 1'b1;
        @(negedge clk);
        check("valid_drop", 32'(bus.resp_valid), 32'd0);
        check("state_idle", 32'(state_dbg), 32'd0);
        @(negedge clk);
        check("no_second", 32'(bus.resp_valid), 32'd0);
    endtask

    task automatic std_seq();
        strobe(0, 32'h5000);
        strobe(1, 32'h4000);
        strobe(2, 32'h3000);
        strobe(3, 32'h3800);
    endtask

    initial begin
        logic [31:0] cnt [NUM_LOOPS];
        logic [FREQ_BITS-1:0] f [NUM_LOOPS];
        logic [1:0] rd;
        bit seen;

        bus.store_response_puf = 1'b0;
        bus.select_puf = '0;
        bus.count_in = '0;
        bus.eval_done = 1'b0;
        bus.resp_ready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_data", 32'(bus.resp_data), 32'd0);
        check("rst_missing", 32'(bus.missing_err), 32'd0);
        check("rst_dup", 32'(bus.dup_err), 32'd0);
        check("rst_state", 32'(state_dbg), 32'd0);

        // first edge after release ignores a strobe
        @(posedge clk); #1;
        reset = 1'b1;
        strobe(0, 32'h7000);
        check("first_edge_ignored", 32'(state_dbg), 32'd0);

        // basic response, captured from the second edge on
        std_seq();
        expect_resp(2'b01, 1'b0, 1'b0);
        eval_pulse(0, 0, 0);
        wait_resp(0, 1);

`ifdef RESPONSE_COLLECTOR_RAW_READOUT_EN
        raw_addr = SEL_W'(1);
        @(negedge clk);
        check("raw_loop1", 32'(raw_data), 32'd4);
        raw_addr = SEL_W'(7);
        @(negedge clk);
        check("raw_out_of_range", 32'(raw_data), 32'd0);
`endif

        // back-pressure for 10 cycles
        std_seq();
        expect_resp(2'b01, 1'b0, 1'b0);
        eval_pulse(0, 0, 0);
        wait_resp(10, 1);

        // loop 3 never captured
        strobe(0, 32'h5000);
        strobe(1, 32'h4000);
        strobe(2, 32'h1000);
        expect_resp(2'b11, 1'b1, 1'b0);
        eval_pulse(0, 0, 0);
        wait_resp(0, 1);

        // loop 1 captured twice, second value wins
        strobe(1, 32'h2000);
        strobe(1, 32'h6000);
        strobe(0, 32'h5000);
        strobe(2, 32'h3000);
        strobe(3, 32'h3800);
        expect_resp(2'b00, 1'b0, 1'b1);
        eval_pulse(0, 0, 0);
        wait_resp(0, 1);

        // saturation: 0xFFFF vs exactly 0xFFFF, and 0x10000 clamped vs 0xFFFE
        strobe(0, 32'hFFFF_FFFF);
        strobe(1, 32'h0FFF_F000);
        strobe(2, 32'h1000_0000);
        strobe(3, 32'h0FFF_E000);
        expect_resp(2'b10, 1'b0, 1'b0);
        eval_pulse(0, 0, 0);
        wait_resp(0, 1);

        // out-of-range loop index is dropped and flagged
        strobe(0, 32'h5000);
        strobe(5, 32'h0);
        strobe(1, 32'h4000);
        strobe(2, 32'h3000);
        strobe(3, 32'h3800);
        expect_resp(2'b01, 1'b0, 1'b1);
        eval_pulse(0, 0, 0);
        wait_resp(0, 1);

        // strobe coinciding with eval_done rise is still captured
        strobe(0, 32'h5000);
        strobe(1, 32'h4000);
        strobe(2, 32'h2000);
        expect_resp(2'b11, 1'b0, 1'b0);
        eval_pulse(1, 3, 32'h1000);
        wait_resp(0, 1);

        // strobe during COMPARE is ignored and flagged
        std_seq();
        expect_resp(2'b01, 1'b0, 1'b1);
        eval_pulse(0, 0, 0);
        strobe(1, 32'h9000);
        wait_resp(0, 0);

        // random rounds against a small reference model
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < NUM_LOOPS; i++) begin
                cnt[i] = $urandom_range(0, 32'h000F_FFFF);
                if ((cnt[i] >> 12) > 32'h0000_FFFF) f[i] = '1;
                else f[i] = FREQ_BITS'(cnt[i] >> 12);
            end
            rd[0] = (f[0] > f[1]);
            rd[1] = (f[2] > f[3]);
            expect_resp(rd, 1'b0, 1'b0);
            for (int i = 0; i < NUM_LOOPS; i++) strobe(i, cnt[i]);
            eval_pulse(0, 0, 0);
            wait_resp(0, 1);
        end

        // reset while a response is being held
        strobe(0, 32'h5000);
        strobe(0, 32'h5000);
        strobe(1, 32'h4000);
        expect_resp(2'b01, 1'b1, 1'b1);
        eval_pulse(0, 0, 0);
        bus.resp_ready = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = bus.resp_valid;
        end
        check("held_before_reset", 32'(bus.resp_valid), 32'd1);
        reset = 1'b0;
        #1;
        check("rst_mid_valid", 32'(bus.resp_valid), 32'd0);
        check("rst_mid_data", 32'(bus.resp_data), 32'd0);
        check("rst_mid_missing", 32'(bus.missing_err), 32'd0);
        check("rst_mid_dup", 32'(bus.dup_err), 32'd0);
        check("rst_mid_state", 32'(state_dbg), 32'd0);
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        @(posedge clk); #1;
        reset = 1'b1;
        bus.resp_ready = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.resp_valid) seen = 1'b1;
        end
        check("no_resp_after_reset", 32'(seen), 32'd0);
        check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
